debug_trace_buffer: RTL and testbench

// Parametrised successor to the flat debug port: captures N_CH 32-bit probe words every enabled

---
 rtl/debug_trace_if.sv | 37 +++
 rtl/debug_trace_buffer.sv | 143 ++++++++++++++
 tb/tb_debug_trace_buffer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_trace_if.sv
// Host/probe-side signal bundle for debug_trace_buffer: probe capture, trigger setup and readout.
// master = instantiator/host side, slave = the trace buffer.
interface debug_trace_if #(
    parameter int N_CH  = 40,
    parameter int DEPTH = 64
);
    localparam int CH_W = $clog2(N_CH);
    localparam int AW   = $clog2(DEPTH);

    logic [N_CH*32-1:0] probes;
    logic               sample_en;
    logic               arm;
    logic               force_trig;
    logic [CH_W-1:0]    trig_ch;
    logic [31:0]        trig_value;
    logic [31:0]        trig_mask;
    logic [AW-1:0]      post_count;
    logic [AW-1:0]      rd_idx;
    logic [CH_W-1:0]    rd_ch;
    logic [31:0]        rd_data;
    logic [1:0]         state_o;
    logic [AW:0]        valid_count;
    logic [AW-1:0]      trig_idx;
    logic               done;

    modport master (
        output probes, sample_en, arm, force_trig, trig_ch, trig_value, trig_mask,
               post_count, rd_idx, rd_ch,
        input  rd_data, state_o, valid_count, trig_idx, done
    );

    modport slave (
        input  probes, sample_en, arm, force_trig, trig_ch, trig_value, trig_mask,
               post_count, rd_idx, rd_ch,
        output rd_data, state_o, valid_count, trig_idx, done
    );
endinterface

// File: rtl/debug_trace_buffer.sv
// Circular multi-channel trace buffer with masked-compare / forced trigger, post-trigger window
// and frozen-history readout. One 32-bit memory lane per probe channel.
module debug_trace_lane #(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [31:0]   wd,
    input  logic [AW-1:0] ra,
    output logic [31:0]   rq
);
    logic [31:0] mem [DEPTH];

    // Registered read sees the pre-write contents on a same-entry collision.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rq <= mem[ra];
    end
endmodule

module debug_trace_buffer #(
    parameter int N_CH  = 40,
    parameter int DEPTH = 64,
    localparam int CH_W = $clog2(N_CH),
    localparam int AW   = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst,
    debug_trace_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
    localparam logic [CH_W:0] NCH_LIM = (CH_W+1)'(N_CH);

    state_t                 state, state_n;
    logic [AW-1:0]          wr_ptr, wr_ptr_n;
    logic [AW:0]            valid_count, valid_count_n;
    logic [AW-1:0]          remaining, remaining_n;
    logic [AW-1:0]          post_lat, post_lat_n;
    logic [AW-1:0]          trig_addr, trig_addr_n;
    logic                   wr_en;

    logic [N_CH-1:0][31:0]  probe_w;
    logic [N_CH-1:0][31:0]  lane_q;
    logic [31:0]            trig_word;
    logic                   hit;
    logic [AW-1:0]          oldest;
    logic [AW-1:0]          rd_addr;
    logic                   rd_ok;
    logic                   rd_vld;
    logic [CH_W-1:0]        rd_ch_q;

    assign probe_w = bus.probes;

    always_comb begin
        trig_word = '0;
        if ({1'b0, bus.trig_ch} < NCH_LIM) trig_word = probe_w[bus.trig_ch];
    end

    assign hit     = bus.force_trig || (((trig_word ^ bus.trig_value) & bus.trig_mask) == '0);
    assign oldest  = (valid_count == FULL) ? wr_ptr : '0;
    assign rd_addr = oldest + bus.rd_idx;
    assign rd_ok   = ({1'b0, bus.rd_idx} < valid_count) && ({1'b0, bus.rd_ch} < NCH_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            valid_count <= '0;
            remaining   <= '0;
            post_lat    <= '0;
            trig_addr   <= '0;
            rd_vld      <= 1'b0;
            rd_ch_q     <= '0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            valid_count <= valid_count_n;
            remaining   <= remaining_n;
            post_lat    <= post_lat_n;
            trig_addr   <= trig_addr_n;
            rd_vld      <= rd_ok;
            rd_ch_q     <= bus.rd_ch;
        end
    end

    // arm wins over everything; a stalled cycle (sample_en=0) leaves all state untouched.
    always_comb begin
        state_n       = state;
        wr_ptr_n      = wr_ptr;
        valid_count_n = valid_count;
        remaining_n   = remaining;
        post_lat_n    = post_lat;
        trig_addr_n   = trig_addr;
        wr_en         = 1'b0;
        if (bus.arm) begin
            state_n       = S_ARMED;
            wr_ptr_n      = '0;
            valid_count_n = '0;
            post_lat_n    = bus.post_count;
            trig_addr_n   = '0;
        end else if ((state == S_ARMED || state == S_POST) && bus.sample_en) begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + AW'(1);
            if (valid_count != FULL) valid_count_n = valid_count + (AW+1)'(1);
            if (state == S_ARMED) begin
                if (hit) begin
                    trig_addr_n = wr_ptr;
                    remaining_n = post_lat;
                    state_n     = (post_lat == '0) ? S_DONE : S_POST;
                end
            end else begin
                remaining_n = remaining - AW'(1);
                if (remaining == AW'(1)) state_n = S_DONE;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        debug_trace_lane #(.DEPTH(DEPTH)) u_lane (
            .clk (clk),
            .we  (wr_en),
            .wa  (wr_ptr),
            .wd  (probe_w[c]),
            .ra  (rd_addr),
            .rq  (lane_q[c])
        );
    end

    assign bus.rd_data     = rd_vld ? lane_q[rd_ch_q] : 32'h0;
    assign bus.state_o     = state;
    assign bus.valid_count = valid_count;
    assign bus.trig_idx    = trig_addr - oldest;
    assign bus.done        = (state == S_DONE);
endmodule

// File: tb/tb_debug_trace_buffer.sv
// Randomised bench for debug_trace_buffer against a queue-based history model.
module tb_debug_trace_buffer;
    localparam int N_CH  = 40;
    localparam int DEPTH = 64;
    localparam int CH_W  = $clog2(N_CH);
    localparam int AW    = $clog2(DEPTH);

    typedef logic [N_CH-1:0][31:0] sample_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_trace_if #(.N_CH(N_CH), .DEPTH(DEPTH)) bus();
    debug_trace_buffer #(.N_CH(N_CH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Model: last DEPTH captured samples in order, plus absolute sample counts since arm.
    sample_t     hist[$];
    sample_t     pv;
    int          m_state, m_post, m_rem, m_total, m_trig_abs;
    logic [31:0] exp_rd;
    int          n_checks, n_err;

    function automatic logic [31:0] model_read(int idx, int ch);
        if (idx >= hist.size() || ch >= N_CH) return 32'h0;
        return hist[idx][ch];
    endfunction

    function automatic int model_trig_idx();
        return m_trig_abs - (m_total - hist.size());
    endfunction

    task automatic rand_probes();
        for (int c = 0; c < N_CH; c++) pv[c] = $urandom;
    endtask

    // Apply pv, advance the model by one clock, then sample #1 after the edge.
    task automatic step();
        bus.probes = pv;
        exp_rd = rst ? 32'h0 : model_read(int'(bus.rd_idx), int'(bus.rd_ch));
        if (rst) begin
            m_state = 0; hist.delete(); m_total = 0; m_trig_abs = 0;
        end else if (bus.arm) begin
            m_state = 1; hist.delete(); m_total = 0; m_trig_abs = 0;
            m_post = int'(bus.post_count);
        end else if ((m_state == 1 || m_state == 2) && bus.sample_en) begin
            hist.push_back(pv);
            m_total++;
            if (hist.size() > DEPTH) void'(hist.pop_front());
            if (m_state == 1) begin
                if (bus.force_trig ||
                    ((pv[bus.trig_ch] & bus.trig_mask) == (bus.trig_value & bus.trig_mask))) begin
                    m_trig_abs = m_total - 1;
                    if (m_post == 0) m_state = 3;
                    else begin m_state = 2; m_rem = m_post; end
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < N_CH; c++) pv[c] = 32'(c + 1);
        step(); step();
        rst = 1'b0;
        n_checks++; if (bus.trig_idx !== '0) begin n_err++; $display("FAIL reset_trig_idx got=%0d exp=0", bus.trig_idx); end
        for (int i = 0; i < 4; i++) begin
            bus.rd_idx = AW'(i * 5);
            bus.rd_ch  = CH_W'(i);
            step();
            n_checks++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", bus.state_o); end
            n_checks++; if (bus.valid_count !== '0) begin n_err++; $display("FAIL reset_vc got=%0d exp=0", bus.valid_count); end
            n_checks++; if (bus.rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd idx=%0d got=%h exp=0", i * 5, bus.rd_data); end
            n_checks++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        end
    endtask

    task automatic test_compare_trigger();
        int n = 0;
        bus.trig_ch = 2; bus.trig_value = 32'h10; bus.trig_mask = '1;
        bus.post_count = 3; bus.force_trig = 1'b0; bus.sample_en = 1'b1;
        arm_pulse();
        n_checks++; if (bus.state_o !== 2'd1 || bus.valid_count !== '0) begin
            n_err++; $display("FAIL cmp_armed state=%0d vc=%0d exp state=1 vc=0", bus.state_o, bus.valid_count); end
        while (!bus.done && n < 40) begin
            n++;
            rand_probes();
            pv[2] = 32'(n);
            step();
        end
        n_checks++; if (bus.done !== 1'b1 || bus.state_o !== 2'd3) begin
            n_err++; $display("FAIL cmp_done done=%b state=%0d exp done=1 state=3", bus.done, bus.state_o); end
        n_checks++; if (bus.valid_count !== 7'd19) begin n_err++; $display("FAIL cmp_vc got=%0d exp=19", bus.valid_count); end
        n_checks++; if (bus.trig_idx !== 6'd15) begin n_err++; $display("FAIL cmp_trig_idx got=%0d exp=15", bus.trig_idx); end
        bus.rd_idx = 15; bus.rd_ch = 2;
        step();
        n_checks++; if (bus.rd_data !== 32'h10 || bus.rd_data !== exp_rd) begin
            n_err++; $display("FAIL cmp_rd_trig got=%h exp=00000010 model=%h", bus.rd_data, exp_rd); end
        for (int i = 0; i < 8; i++) begin
            rand_probes();
            bus.rd_idx = AW'($urandom_range(0, 24));
            bus.rd_ch  = CH_W'($urandom_range(0, 63));
            step();
            n_checks++; if (bus.rd_data !== exp_rd) begin
                n_err++; $display("FAIL cmp_rd_rand idx=%0d ch=%0d got=%h exp=%h", bus.rd_idx, bus.rd_ch, bus.rd_data, exp_rd); end
        end
    endtask

    task automatic test_wrap_force();
        bus.trig_ch = 0; bus.trig_value = 32'hFFFF_FFFF; bus.trig_mask = '1;
        bus.post_count = 0; bus.sample_en = 1'b1;
        arm_pulse();
        for (int k = 0; k < 100; k++) begin
            rand_probes();
            pv[0] = 32'(k);
            step();
        end
        n_checks++; if (bus.state_o !== 2'd1 || bus.valid_count !== 7'd64) begin
            n_err++; $display("FAIL wrap_pre state=%0d vc=%0d exp state=1 vc=64", bus.state_o, bus.valid_count); end
        rand_probes();
        pv[0] = 32'd100;
        bus.force_trig = 1'b1;
        step();
        bus.force_trig = 1'b0;
        n_checks++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL wrap_done got=%b exp=1", bus.done); end
        n_checks++; if (bus.valid_count !== 7'd64) begin n_err++; $display("FAIL wrap_vc got=%0d exp=64", bus.valid_count); end
        n_checks++; if (bus.trig_idx !== 6'd63 || int'(bus.trig_idx) !== model_trig_idx()) begin
            n_err++; $display("FAIL wrap_trig_idx got=%0d exp=63 model=%0d", bus.trig_idx, model_trig_idx()); end
        bus.rd_idx = 0; bus.rd_ch = 0;
        step();
        n_checks++; if (bus.rd_data !== 32'd37 || bus.rd_data !== exp_rd) begin
            n_err++; $display("FAIL wrap_rd_oldest got=%0d exp=37", bus.rd_data); end
        bus.rd_idx = 63;
        step();
        n_checks++; if (bus.rd_data !== 32'd100) begin n_err++; $display("FAIL wrap_rd_newest got=%0d exp=100", bus.rd_data); end
    endtask

    task automatic test_sample_en();
        int cyc = 0, en_cnt = 0, trig_en = 0;
        logic [31:0] tmp;
        bit en;
        bus.trig_ch = 1; bus.trig_value = 32'h0000_ABCD; bus.trig_mask = 32'h0000_FFFF;
        bus.post_count = 4; bus.sample_en = 1'b1;
        arm_pulse();
        while (!bus.done && cyc < 80) begin
            rand_probes();
            tmp = $urandom;
            pv[1] = {tmp[31:16], 16'h1234};
            en = 1'($urandom_range(0, 1));
            if (cyc == 5)  begin en = 1'b0; pv[1] = {tmp[31:16], 16'hABCD}; end
            if (cyc == 12) begin en = 1'b1; pv[1] = {tmp[31:16], 16'hABCD}; end
            bus.sample_en = en;
            if (en) en_cnt++;
            if (cyc == 12) trig_en = en_cnt;
            step();
            cyc++;
            n_checks++; if (int'(bus.state_o) !== m_state || int'(bus.valid_count) !== hist.size()) begin
                n_err++; $display("FAIL en_track cyc=%0d state=%0d/%0d vc=%0d/%0d", cyc, bus.state_o, m_state, bus.valid_count, hist.size()); end
            if (cyc == 6) begin
                n_checks++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL en_stall_trig state=%0d exp=1", bus.state_o); end
            end
        end
        bus.sample_en = 1'b1;
        n_checks++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL en_done timeout got=%b exp=1", bus.done); end
        n_checks++; if (int'(bus.valid_count) !== trig_en + 4 || int'(bus.valid_count) !== en_cnt) begin
            n_err++; $display("FAIL en_vc got=%0d exp=%0d", bus.valid_count, trig_en + 4); end
        n_checks++; if (int'(bus.trig_idx) !== trig_en - 1) begin n_err++; $display("FAIL en_trig_idx got=%0d exp=%0d", bus.trig_idx, trig_en - 1); end
    endtask

    task automatic test_rearm_rst();
        bus.trig_mask = '0; bus.post_count = 10; bus.sample_en = 1'b1;
        arm_pulse();
        rand_probes(); step();
        n_checks++; if (bus.state_o !== 2'd2) begin n_err++; $display("FAIL rearm_post state=%0d exp=2", bus.state_o); end
        rand_probes(); step();
        bus.post_count = 0;
        arm_pulse();
        n_checks++; if (bus.state_o !== 2'd1 || bus.valid_count !== '0) begin
            n_err++; $display("FAIL rearm_in_post state=%0d vc=%0d exp state=1 vc=0", bus.state_o, bus.valid_count); end
        rand_probes(); step();
        n_checks++; if (bus.done !== 1'b1 || bus.valid_count !== 7'd1) begin
            n_err++; $display("FAIL rearm_done done=%b vc=%0d exp done=1 vc=1", bus.done, bus.valid_count); end
        bus.post_count = 10;
        arm_pulse();
        n_checks++; if (bus.state_o !== 2'd1 || bus.valid_count !== '0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL rearm_in_done state=%0d vc=%0d done=%b exp 1/0/0", bus.state_o, bus.valid_count, bus.done); end
        rand_probes(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (bus.state_o !== 2'd0 || bus.done !== 1'b0 || bus.valid_count !== '0) begin
            n_err++; $display("FAIL rst_in_post state=%0d done=%b vc=%0d exp 0/0/0", bus.state_o, bus.done, bus.valid_count); end
    endtask

    task automatic test_long_post();
        int n = 0;
        bus.trig_ch = 3; bus.trig_value = 32'hDEAD_BEEF; bus.trig_mask = '1;
        bus.post_count = 63; bus.sample_en = 1'b1;
        arm_pulse();
        for (int k = 0; k < 5; k++) begin rand_probes(); pv[3] = 32'(k); step(); end
        rand_probes(); pv[3] = 32'hDEAD_BEEF; step();
        n_checks++; if (bus.state_o !== 2'd2) begin n_err++; $display("FAIL long_post state=%0d exp=2", bus.state_o); end
        while (!bus.done && n < 80) begin n++; rand_probes(); step(); end
        n_checks++; if (bus.done !== 1'b1 || bus.valid_count !== 7'd64) begin
            n_err++; $display("FAIL long_done done=%b vc=%0d exp done=1 vc=64", bus.done, bus.valid_count); end
        n_checks++; if (bus.trig_idx !== '0) begin n_err++; $display("FAIL long_trig_idx got=%0d exp=0", bus.trig_idx); end
        bus.rd_idx = 0; bus.rd_ch = 3;
        step();
        n_checks++; if (bus.rd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL long_rd_trig got=%h exp=deadbeef", bus.rd_data); end
        bus.rd_ch = CH_W'(N_CH);
        step();
        n_checks++; if (bus.rd_data !== 32'h0) begin n_err++; $display("FAIL long_rd_badch got=%h exp=0", bus.rd_data); end
        bus.post_count = 0;
        arm_pulse();
        for (int k = 0; k < 3; k++) begin rand_probes(); pv[3] = 32'(k); step(); end
        n_checks++; if (bus.valid_count !== 7'd3 || bus.state_o !== 2'd1) begin
            n_err++; $display("FAIL short_vc vc=%0d state=%0d exp vc=3 state=1", bus.valid_count, bus.state_o); end
        bus.rd_idx = 10; bus.rd_ch = 0;
        step();
        n_checks++; if (bus.rd_data !== 32'h0) begin n_err++; $display("FAIL short_rd_oob got=%h exp=0", bus.rd_data); end
        bus.sample_en = 1'b0;
        bus.rd_idx = 1; bus.rd_ch = 3;
        step();
        n_checks++; if (bus.rd_data !== 32'd1 || bus.rd_data !== exp_rd) begin
            n_err++; $display("FAIL short_rd got=%h exp=1", bus.rd_data); end
        bus.sample_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_err = 0;
        m_state = 0; m_post = 0; m_rem = 0; m_total = 0; m_trig_abs = 0;
        rst = 1'b1;
        pv = '0;
        bus.probes = '0; bus.sample_en = 1'b0; bus.arm = 1'b0; bus.force_trig = 1'b0;
        bus.trig_ch = '0; bus.trig_value = '0; bus.trig_mask = '0; bus.post_count = '0;
        bus.rd_idx = '0; bus.rd_ch = '0;
        test_reset();
        test_compare_trigger();
        test_wrap_force();
        test_sample_en();
        test_rearm_rst();
        test_long_post();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
